caeser_enc: RTL and testbench
=============================

CAESER_ENC -- requirements
Module: caeser_enc

Interface
REQ-001 Parameter D_WIDTH, default 8: character width in bits.
REQ-002 Parameter KEY_WIDTH, default 16: raw key width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer entries; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_p  input  D_WIDTH  plaintext character.
REQ-007 valid_p  input  1  data_p valid.
REQ-008 ready_p  output  1  block accepts data_p this cycle.
REQ-009 key  input  KEY_WIDTH  raw shift key.
REQ-010 key_load  input  1  one-cycle strobe that samples key.
REQ-011 data_e  output  D_WIDTH  ciphertext character, taken from the FIFO head.
REQ-012 valid_e  output  1  data_e valid.
REQ-013 ready_e  input  1  downstream decryptor accepts data_e.
REQ-014 key_ready  output  1  high when the reduced shift is in use (state RUN).
REQ-015 level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-016 State machine: IDLE (no key), REDUCE (key mod 26 in progress), RUN.
REQ-017 key_load in any state: latch key, clear the remainder, set the bit index to KEY_WIDTH-1, go to REDUCE. If already in REDUCE, the reduction restarts with the new key.
REQ-018 REDUCE, per cycle: remainder = {remainder, key bit}; subtract 26 if the result is >= 26; bit index decrements.
REQ-019 REDUCE lasts exactly KEY_WIDTH cycles; shift <= remainder and go to RUN. With key_load at edge N, key_ready and ready_p are first high after edge N+KEY_WIDTH.
REQ-020 ready_p = (state==RUN) && !full && !key_load; a character transfers when valid_p && ready_p.
REQ-021 Encryption rules:
- 'A'..'Z' (0x41-0x5A): out = 'A' + ((c-'A'+shift) mod 26).
- 'a'..'z' (0x61-0x7A): out = 'a' + ((c-'a'+shift) mod 26).
- All other codes pass through unchanged.
- Wrap is computed as a single conditional subtract of 26; no carry out of D_WIDTH.
REQ-022 The encrypted character is written to the FIFO tail at the transfer edge. Latency into an empty FIFO: 1 cycle (valid_e high the cycle after transfer).
REQ-023 Pop when valid_e && ready_e. valid_e = !empty. data_e is stable while valid_e && !ready_e.
REQ-024 Simultaneous push and pop: occupancy unchanged; order preserved.
REQ-025 Pointers wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH); empty = (level==0).
REQ-026 Characters already in the FIFO keep their old-key ciphertext across a key_load; the FIFO keeps draining during REDUCE.
REQ-027 Characters presented in IDLE or REDUCE are not accepted (ready_p=0); nothing is dropped silently.

Reset
REQ-028 On reset: state=IDLE, shift=0, remainder=0, FIFO pointers and level=0.
REQ-029 On reset, outputs: valid_e=0, ready_p=0, key_ready=0, data_e=0.
REQ-030 Reset has priority over key_load and over any transfer in the same cycle.
REQ-031 Reset mid-REDUCE or mid-stream discards the key and all buffered characters; a new key_load is required.

Verification
REQ-032 key=3, load; after 16 cycles send 'A','z','5' with ready_e=1 -> data_e 0x44 ('D'), 0x63 ('c'), 0x35, each 1 cycle after its transfer.
REQ-033 key=0xFFFF (shift 15), send 'Y' -> 0x4E ('N'). key=29 (shift 3), send 'x' -> 0x61 ('a').
REQ-034 Back-pressure: ready_e=0, send 'a','b','c','d' with key=1 -> level=4, ready_p=0. Then ready_e=1 -> 'b','c','d','e' drain in order on consecutive cycles; ready_p returns high after the first pop.
REQ-035 key_load=1 with valid_p=1 in RUN -> no transfer that cycle. ready_p stays 0 for 16 cycles while buffered characters continue to drain.
REQ-036 reset asserted during REDUCE with 2 FIFO entries -> next cycle valid_e=0, level=0, key_ready=0; valid_p is ignored until a new key_load completes.

Source files
------------

// File: rtl/caeser_enc.sv
// Caesar-shift encryptor: reduces a raw key mod 26 bit-serially, then shifts letters into an
// output FIFO that drains to a downstream consumer with valid/ready handshaking.
module caeser_enc #(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [D_WIDTH-1:0]          data_p,
  input  logic                        valid_p,
  output logic                        ready_p,
  input  logic [KEY_WIDTH-1:0]        key,
  input  logic                        key_load,
  output logic [D_WIDTH-1:0]          data_e,
  output logic                        valid_e,
  input  logic                        ready_e,
  output logic                        key_ready,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReduce = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [4:0]           rem_q, rem_d;
  logic [4:0]           shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [5:0]           rem_ext;

  // Restoring long division by 26, one key bit per cycle, MSB first.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    rem_ext = {rem_q, key_q[idx_q]};
    if (rem_ext >= 6'd26) rem_ext = rem_ext - 6'd26;
    if (key_load) begin
      key_d   = key;
      rem_d   = '0;
      idx_d   = IW'(KEY_WIDTH - 1);
      state_d = StReduce;
    end else if (state_q == StReduce) begin
      rem_d = rem_ext[4:0];
      idx_d = idx_q - IW'(1);
      if (idx_q == '0) begin
        shift_d = rem_ext[4:0];
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      key_q   <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  logic               is_upper, is_lower;
  logic [4:0]         off;
  logic [5:0]         sum;
  logic [D_WIDTH-1:0] enc;

  // Both letter ranges have low five bits 1..26, so only the low bits change.
  always_comb begin
    is_upper = (data_p >= D_WIDTH'(8'h41)) && (data_p <= D_WIDTH'(8'h5A));
    is_lower = (data_p >= D_WIDTH'(8'h61)) && (data_p <= D_WIDTH'(8'h7A));
    off      = data_p[4:0] - 5'd1;
    sum      = {1'b0, off} + {1'b0, shift_q};
    if (sum >= 6'd26) sum = sum - 6'd26;
    enc = data_p;
    if (is_upper || is_lower) enc[4:0] = sum[4:0] + 5'd1;
  end

  logic [D_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q;
  logic               full, empty, push, pop;

  always_comb begin
    full      = (level_q == LW'(FIFO_DEPTH));
    empty     = (level_q == '0);
    key_ready = (state_q == StRun);
    ready_p   = key_ready && !full && !key_load;
    valid_e   = !empty;
    push      = valid_p && ready_p;
    pop       = valid_e && ready_e;
    data_e    = valid_e ? mem_q[rd_ptr_q] : '0;
    level     = level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= enc;
  end

endmodule

// File: tb/tb_caeser_enc.sv
// Scoreboard bench for caeser_enc: expected ciphertext queued at issue, checked by a monitor.
module tb_caeser_enc;

  localparam int KW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_p;
  logic       valid_p;
  logic       ready_p;
  logic [15:0] key;
  logic       key_load;
  logic [7:0] data_e;
  logic       valid_e;
  logic       ready_e;
  logic       key_ready;
  logic [2:0] level;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         shift_m = 0;
  bit         rand_re = 1'b0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  caeser_enc #(
    .D_WIDTH   (8),
    .KEY_WIDTH (KW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_p   (data_p),
    .valid_p  (valid_p),
    .ready_p  (ready_p),
    .key      (key),
    .key_load (key_load),
    .data_e   (data_e),
    .valid_e  (valid_e),
    .ready_e  (ready_e),
    .key_ready(key_ready),
    .level    (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc_m(input logic [7:0] c, input int s);
    int ci;
    ci = int'(c);
    if (ci >= 65 && ci <= 90)  return 8'(65 + (ci - 65 + s) % 26);
    if (ci >= 97 && ci <= 122) return 8'(97 + (ci - 97 + s) % 26);
    return c;
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks head stability under back-pressure.
  initial begin
    bit         hold_v;
    logic [7:0] hold_d;
    logic [7:0] exp;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("valid_e_held", 32'(valid_e), 32'(1));
          check("data_e_stable", 32'(data_e), 32'(hold_d));
        end
        if (valid_e && ready_e) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, expected none at %0t", data_e, $time);
          end else begin
            exp = sb.pop_front();
            check("data_e", 32'(data_e), 32'(exp));
          end
        end
        hold_v = valid_e && !ready_e;
        hold_d = data_e;
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] c);
    bit ok;
    ok      = 1'b0;
    data_p  = c;
    valid_p = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_p) begin
        sb.push_back(enc_m(c, shift_m));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rand_re) ready_e = 1'($urandom_range(0, 1));
      if (ok) break;
    end
    valid_p = 1'b0;
    if (!ok) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic pulse_load(input logic [15:0] k);
    key      = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    shift_m  = int'(k) % 26;
  endtask

  task automatic wait_key_ready(input int exp_cycles);
    int n;
    int rdy;
    n   = 0;
    rdy = 0;
    while (!key_ready && n < 200) begin
      @(negedge clk);
      if (ready_p) rdy++;
      @(posedge clk);
      #1;
      n++;
    end
    check("key_latency", 32'(n), 32'(exp_cycles));
    check("ready_p_in_reduce", 32'(rdy), 32'(0));
  endtask

  task automatic drain();
    int n;
    n       = 0;
    ready_e = 1'b1;
    while ((level != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_level", 32'(level), 32'(0));
    check("drain_sb_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy;
    logic [7:0] c;
    reset    = 1'b1;
    data_p   = '0;
    valid_p  = 1'b0;
    key      = '0;
    key_load = 1'b0;
    ready_e  = 1'b0;
    repeat (2) tick();
    check("rst_valid_e", 32'(valid_e), 32'(0));
    check("rst_ready_p", 32'(ready_p), 32'(0));
    check("rst_key_ready", 32'(key_ready), 32'(0));
    check("rst_data_e", 32'(data_e), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    reset = 1'b0;

    // No key yet: nothing accepted.
    valid_p = 1'b1;
    data_p  = 8'h41;
    rdy     = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready_p) rdy++;
      tick();
    end
    valid_p = 1'b0;
    check("idle_ready_p", 32'(rdy), 32'(0));
    check("idle_level", 32'(level), 32'(0));

    // Basic shift of 3 with one-cycle latency.
    ready_e = 1'b1;
    pulse_load(16'd3);
    wait_key_ready(KW);
    send(8'h41);
    check("lat_A_valid", 32'(valid_e), 32'(1));
    check("lat_A_data", 32'(data_e), 32'(8'h44));
    send(8'h7A);
    check("lat_z_data", 32'(data_e), 32'(8'h63));
    send(8'h35);
    check("lat_5_data", 32'(data_e), 32'(8'h35));
    tick();

    // Key reduction corner values.
    pulse_load(16'hFFFF);
    wait_key_ready(KW);
    send(8'h59);
    check("Y_shift15", 32'(data_e), 32'(8'h4E));
    tick();
    pulse_load(16'd29);
    wait_key_ready(KW);
    send(8'h78);
    check("x_shift3", 32'(data_e), 32'(8'h61));
    tick();

    // Back-pressure fills the FIFO, then drains in order.
    ready_e = 1'b0;
    pulse_load(16'd1);
    wait_key_ready(KW);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h64);
    check("bp_level_full", 32'(level), 32'(4));
    check("bp_ready_p_full", 32'(ready_p), 32'(0));
    ready_e = 1'b1;
    tick();
    check("bp_ready_p_after_pop", 32'(ready_p), 32'(1));
    check("bp_level_after_pop", 32'(level), 32'(3));
    repeat (3) tick();
    check("bp_level_drained", 32'(level), 32'(0));

    // key_load blocks a simultaneous transfer; FIFO keeps draining during reduction.
    ready_e = 1'b0;
    send(8'h6D);
    send(8'h6E);
    key      = 16'd5;
    key_load = 1'b1;
    valid_p  = 1'b1;
    data_p   = 8'h71;
    @(negedge clk);
    check("ready_p_on_load", 32'(ready_p), 32'(0));
    tick();
    key_load = 1'b0;
    valid_p  = 1'b0;
    shift_m  = 5;
    check("no_push_on_load", 32'(level), 32'(2));
    ready_e = 1'b1;
    wait_key_ready(KW);
    check("drained_in_reduce", 32'(level), 32'(0));
    send(8'h71);
    tick();

    // Reset mid-reduction discards buffered characters and the key.
    ready_e = 1'b0;
    send(8'h41);
    send(8'h42);
    pulse_load(16'd7);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid_e", 32'(valid_e), 32'(0));
    check("mid_rst_level", 32'(level), 32'(0));
    check("mid_rst_key_ready", 32'(key_ready), 32'(0));
    check("mid_rst_data_e", 32'(data_e), 32'(0));
    sb.delete();
    reset   = 1'b0;
    ready_e = 1'b1;
    valid_p = 1'b1;
    data_p  = 8'h61;
    rdy     = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready_p) rdy++;
      tick();
    end
    valid_p = 1'b0;
    check("post_rst_ready_p", 32'(rdy), 32'(0));
    check("post_rst_level", 32'(level), 32'(0));

    // Randomized traffic with random keys and random back-pressure.
    rand_re = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) begin
        pulse_load(16'($urandom_range(0, 65535)));
        wait_key_ready(KW);
      end
      case ($urandom_range(0, 3))
        0:       c = 8'($urandom_range(0, 255));
        1:       c = 8'(65 + $urandom_range(0, 25));
        default: c = 8'(97 + $urandom_range(0, 25));
      endcase
      send(c);
      if ($urandom_range(0, 3) == 0) begin
        ready_e = 1'($urandom_range(0, 1));
        tick();
      end
    end
    rand_re = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
